// File: rtl/red_pitaya_exp_in_if.sv
// System-bus port bundle for the expansion-input conditioner.
// The master drives the strobes, address and write data; the slave answers.
interface red_pitaya_exp_in_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr,
        output sys_wdata,
        output sys_wen,
        output sys_ren,
        input  sys_rdata,
        input  sys_err,
        input  sys_ack
    );

    modport slave (
        input  sys_addr,
        input  sys_wdata,
        input  sys_wen,
        input  sys_ren,
        output sys_rdata,
        output sys_err,
        output sys_ack
    );
endinterface

// File: rtl/red_pitaya_exp_in.sv
// Expansion-connector input conditioner: synchronise, debounce and latch edge events
// for the P and N pads, with a maskable level interrupt and system-bus register access.
module red_pitaya_exp_in #(
    parameter int unsigned DWE = 8,
    parameter int unsigned DBW = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DWE-1:0]     exp_p_pad_i,
    input  logic [DWE-1:0]     exp_n_pad_i,
    output logic [DWE-1:0]     exp_p_dat_o,
    output logic [DWE-1:0]     exp_n_dat_o,
    output logic               irq_o,
    red_pitaya_exp_in_if.slave sys
);

    // Channel c < DWE is a P pin; channel c >= DWE is N pin (c - DWE).
    localparam int unsigned NCH = 2 * DWE;

    localparam logic [19:0] AddrDebLen = 20'h00000;
    localparam logic [19:0] AddrRiseEn = 20'h00004;
    localparam logic [19:0] AddrFallEn = 20'h00008;
    localparam logic [19:0] AddrEvent  = 20'h0000C;
    localparam logic [19:0] AddrIrqEn  = 20'h00010;
    localparam logic [19:0] AddrState  = 20'h00014;
    localparam logic [19:0] AddrRaw    = 20'h00018;

    logic [NCH-1:0] s1_q;
    logic [NCH-1:0] s2_q;
    logic [NCH-1:0] deb_q;
    logic [NCH-1:0] deb_d;
    logic [DBW-1:0] cnt_q [NCH];
    logic [DBW-1:0] cnt_d [NCH];
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;

    logic [DBW-1:0] deb_len_q;
    logic [DBW-1:0] deb_len_d;
    logic [NCH-1:0] rise_en_q;
    logic [NCH-1:0] rise_en_d;
    logic [NCH-1:0] fall_en_q;
    logic [NCH-1:0] fall_en_d;
    logic [NCH-1:0] event_q;
    logic [NCH-1:0] event_d;
    logic [NCH-1:0] irq_en_q;
    logic [NCH-1:0] irq_en_d;
    logic [NCH-1:0] w1c;

    logic           irq_q;
    logic           ack_q;
    logic [31:0]    rdata_q;
    logic [31:0]    rdata_d;

    logic [19:0]    addr;
    logic [NCH-1:0] wdata_ch;
    logic           unused_bus;

    assign addr       = sys.sys_addr[19:0];
    assign wdata_ch   = {sys.sys_wdata[16 +: DWE], sys.sys_wdata[DWE-1:0]};
    assign unused_bus = ^{sys.sys_addr[31:20], sys.sys_wdata};

    // Spread a channel vector onto the bus layout: P at [DWE-1:0], N at [16 +: DWE].
    function automatic logic [31:0] to_bus(input logic [NCH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[DWE-1:0]  = v[DWE-1:0];
        r[16 +: DWE] = v[NCH-1:DWE];
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {exp_n_pad_i, exp_p_pad_i};
            s2_q <= s1_q;
        end
    end

    // Compare against the live DEB_LEN so lowering it releases a pending change at once.
    always_comb begin
        deb_d = deb_q;
        rise  = '0;
        fall  = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (s2_q[c] == deb_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] >= deb_len_q) begin
                deb_d[c] = s2_q[c];
                cnt_d[c] = '0;
                rise[c]  = s2_q[c];
                fall[c]  = ~s2_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    always_comb begin
        deb_len_d = deb_len_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        w1c       = '0;
        if (sys.sys_wen) begin
            case (addr)
                AddrDebLen: deb_len_d = sys.sys_wdata[DBW-1:0];
                AddrRiseEn: rise_en_d = wdata_ch;
                AddrFallEn: fall_en_d = wdata_ch;
                AddrEvent:  w1c       = wdata_ch;
                AddrIrqEn:  irq_en_d  = wdata_ch;
                default:    ;
            endcase
        end
        // A new event on the same edge as a W1C clear keeps the bit set.
        event_d = (event_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        rdata_d = '0;
        if (sys.sys_ren) begin
            case (addr)
                AddrDebLen: rdata_d = 32'(deb_len_q);
                AddrRiseEn: rdata_d = to_bus(rise_en_q);
                AddrFallEn: rdata_d = to_bus(fall_en_q);
                AddrEvent:  rdata_d = to_bus(event_q);
                AddrIrqEn:  rdata_d = to_bus(irq_en_q);
                AddrState:  rdata_d = to_bus(deb_q);
                AddrRaw:    rdata_d = to_bus(s2_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_len_q <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            event_q   <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            deb_len_q <= deb_len_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            event_q   <= event_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= |(event_q & irq_en_q);
            ack_q     <= sys.sys_wen | sys.sys_ren;
            rdata_q   <= rdata_d;
        end
    end

    assign exp_p_dat_o   = deb_q[DWE-1:0];
    assign exp_n_dat_o   = deb_q[NCH-1:DWE];
    assign irq_o         = irq_q;
    assign sys.sys_rdata = rdata_q;
    assign sys.sys_ack   = ack_q;
    assign sys.sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_exp_in.sv
// Self-checking bench for red_pitaya_exp_in: read expectations are queued when a read
// strobe is driven and popped when the acknowledged data appears.
module tb_red_pitaya_exp_in;

    localparam logic [31:0] ADebLen = 32'h00;
    localparam logic [31:0] ARiseEn = 32'h04;
    localparam logic [31:0] AFallEn = 32'h08;
    localparam logic [31:0] AEvent  = 32'h0C;
    localparam logic [31:0] AIrqEn  = 32'h10;
    localparam logic [31:0] AState  = 32'h14;
    localparam logic [31:0] ARaw    = 32'h18;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_pad;
    logic [7:0] n_pad;
    logic [7:0] p_dat;
    logic [7:0] n_dat;
    logic       irq;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got;
    logic [31:0] want;
    logic        ack;
    logic        seen;

    red_pitaya_exp_in_if sys_bus ();

    red_pitaya_exp_in #(
        .DWE(8),
        .DBW(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .exp_p_pad_i(p_pad),
        .exp_n_pad_i(n_pad),
        .exp_p_dat_o(p_dat),
        .exp_n_dat_o(n_dat),
        .irq_o      (irq),
        .sys        (sys_bus)
    );

    always #5 clk = ~clk;

    // All bus tasks start and end just after a falling edge; one call spans one clock.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        sys_bus.sys_addr  = addr;
        sys_bus.sys_wdata = data;
        sys_bus.sys_wen   = 1'b1;
        @(negedge clk);
        sys_bus.sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] expv,
                            output logic [31:0] r_got, output logic [31:0] r_want,
                            output logic r_ack);
        sys_bus.sys_addr = addr;
        sys_bus.sys_ren  = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        sys_bus.sys_ren  = 1'b0;
        r_got  = sys_bus.sys_rdata;
        r_ack  = sys_bus.sys_ack;
        r_want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        p_pad = '0;
        n_pad = '0;
        sys_bus.sys_addr  = '0;
        sys_bus.sys_wdata = '0;
        sys_bus.sys_wen   = 1'b0;
        sys_bus.sys_ren   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({p_dat, n_dat, irq, sys_bus.sys_rdata, sys_bus.sys_ack, sys_bus.sys_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: p=%h n=%h irq=%b rdata=%h ack=%b err=%b, all must be 0",
                     p_dat, n_dat, irq, sys_bus.sys_rdata, sys_bus.sys_ack, sys_bus.sys_err);
        end
        rst = 1'b0;
        for (int a = 0; a <= 24; a += 4) begin
            bus_read(32'(a), 32'h0, got, want, ack);
            checks++;
            if (ack !== 1'b1 || got !== want) begin
                failures++;
                $display("FAIL reset_reg_%0h: got=%h ack=%b want=%h ack=1", a, got, ack, want);
            end
        end
    endtask

    task automatic test_bypass();
        bus_write(ARiseEn, 32'h1);
        bus_write(AIrqEn, 32'h1);
        p_pad[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (p_dat !== 8'h00) begin
            failures++;
            $display("FAIL bypass_k1: p_dat=%h want=00", p_dat);
        end
        @(negedge clk);
        checks++;
        if (p_dat !== 8'h01 || irq !== 1'b0) begin
            failures++;
            $display("FAIL bypass_k2: p_dat=%h irq=%b want p_dat=01 irq=0", p_dat, irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL bypass_irq_k3: irq=%b want=1", irq);
        end
        bus_read(AState, 32'h0000_0001, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL bypass_state: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_read(AEvent, 32'h0000_0001, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL bypass_event: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_read(ARaw, 32'h0000_0001, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL bypass_raw: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_write(AEvent, 32'hFFFF_FFFF);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL bypass_irq_on_w1c_edge: irq=%b want=1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL bypass_irq_after_w1c: irq=%b want=0", irq);
        end
        bus_write(ARiseEn, 32'h0);
        bus_write(AIrqEn, 32'h0);
        p_pad[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        bus_write(ADebLen, 32'd4);
        bus_write(ARiseEn, 32'h0004_0000);
        n_pad[2] = 1'b1;
        repeat (4) @(negedge clk);
        n_pad[2] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (n_dat !== 8'h00) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL glitch_4cyc_output: n_dat went nonzero, want stays 00");
        end
        bus_read(AEvent, 32'h0, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL glitch_event: got=%h ack=%b want=%h", got, ack, want);
        end
        n_pad[2] = 1'b1;
        repeat (5) @(negedge clk);
        n_pad[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (n_dat !== 8'h00) begin
            failures++;
            $display("FAIL glitch_5cyc_k5: n_dat=%h want=00", n_dat);
        end
        @(negedge clk);
        checks++;
        if (n_dat !== 8'h04) begin
            failures++;
            $display("FAIL glitch_5cyc_k6: n_dat=%h want=04", n_dat);
        end
        bus_read(AState, 32'h0004_0000, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL glitch_state: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_read(AEvent, 32'h0004_0000, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL glitch_event_set: got=%h ack=%b want=%h", got, ack, want);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (n_dat !== 8'h00) begin
            failures++;
            $display("FAIL glitch_release: n_dat=%h want=00", n_dat);
        end
        bus_write(AEvent, 32'hFFFF_FFFF);
        bus_write(ARiseEn, 32'h0);
        bus_write(ADebLen, 32'h0);
    endtask

    task automatic test_fall_w1c();
        bus_write(AFallEn, 32'h80);
        bus_write(AIrqEn, 32'h80);
        p_pad[7] = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(AEvent, 32'h0, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want || p_dat !== 8'h80) begin
            failures++;
            $display("FAIL fall_rise_no_event: event=%h p_dat=%h want event=%h p_dat=80",
                     got, p_dat, want);
        end
        p_pad[7] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL fall_irq: irq=%b want=1", irq);
        end
        bus_read(AEvent, 32'h80, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL fall_event: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_write(AEvent, 32'h80);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL fall_irq_w1c_edge: irq=%b want=1", irq);
        end
        bus_read(AEvent, 32'h0, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want || irq !== 1'b0) begin
            failures++;
            $display("FAIL fall_w1c: event=%h irq=%b want event=%h irq=0", got, irq, want);
        end
        bus_write(AFallEn, 32'h0);
        bus_write(AIrqEn, 32'h0);
    endtask

    task automatic test_set_wins();
        bus_write(ARiseEn, 32'h1);
        p_pad[0] = 1'b1;
        repeat (2) @(negedge clk);
        // This W1C strobe lands on the same edge that sets EVENT[0].
        bus_write(AEvent, 32'h1);
        bus_read(AEvent, 32'h1, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL set_wins: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_write(AEvent, 32'h1);
        bus_read(AEvent, 32'h0, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL set_wins_later_clear: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_write(ARiseEn, 32'h0);
        p_pad[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_bus_decode();
        bus_read(32'h1C, 32'h0, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want || sys_bus.sys_err !== 1'b0) begin
            failures++;
            $display("FAIL decode_1c: got=%h ack=%b err=%b want=%h ack=1 err=0",
                     got, ack, sys_bus.sys_err, want);
        end
        bus_read(32'h40, 32'h0, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want || sys_bus.sys_err !== 1'b0) begin
            failures++;
            $display("FAIL decode_40: got=%h ack=%b err=%b want=%h ack=1 err=0",
                     got, ack, sys_bus.sys_err, want);
        end
        @(negedge clk);
        checks++;
        if (sys_bus.sys_ack !== 1'b0 || sys_bus.sys_err !== 1'b0) begin
            failures++;
            $display("FAIL decode_idle_ack: ack=%b err=%b want ack=0 err=0",
                     sys_bus.sys_ack, sys_bus.sys_err);
        end
        bus_write(ARiseEn, 32'hFFFF_FFFF);
        bus_read(ARiseEn, 32'h00FF_00FF, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL decode_rise_mask: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_write(32'h1C, 32'h0);
        bus_read(32'h4010_0004, 32'h00FF_00FF, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL decode_alias: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_write(ADebLen, 32'hFFFF_FFFF);
        bus_read(ADebLen, 32'h0000_FFFF, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL decode_deblen_mask: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_write(ADebLen, 32'h0);
        bus_write(ARiseEn, 32'h0);
    endtask

    task automatic test_back_to_back();
        bus_write(AFallEn, 32'h0003_0001);
        bus_write(AIrqEn, 32'h0000_0080);
        sys_bus.sys_ren  = 1'b1;
        sys_bus.sys_addr = AFallEn;
        exp_q.push_back(32'h0003_0001);
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (sys_bus.sys_ack !== 1'b1 || sys_bus.sys_rdata !== want) begin
            failures++;
            $display("FAIL b2b_first: got=%h ack=%b want=%h", sys_bus.sys_rdata,
                     sys_bus.sys_ack, want);
        end
        sys_bus.sys_addr = AIrqEn;
        exp_q.push_back(32'h0000_0080);
        @(negedge clk);
        sys_bus.sys_ren = 1'b0;
        want = exp_q.pop_front();
        checks++;
        if (sys_bus.sys_ack !== 1'b1 || sys_bus.sys_rdata !== want) begin
            failures++;
            $display("FAIL b2b_second: got=%h ack=%b want=%h", sys_bus.sys_rdata,
                     sys_bus.sys_ack, want);
        end
        @(negedge clk);
        checks++;
        if (sys_bus.sys_ack !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ack_drop: ack=%b want=0", sys_bus.sys_ack);
        end
        bus_write(AFallEn, 32'h0);
        bus_write(AIrqEn, 32'h0);
    endtask

    task automatic test_reset_mid_count();
        p_pad[1] = 1'b1;
        repeat (4) @(negedge clk);
        bus_write(ADebLen, 32'd100);
        bus_write(ARiseEn, 32'h1);
        p_pad[0] = 1'b1;
        repeat (52) @(negedge clk);
        checks++;
        if (p_dat !== 8'h02) begin
            failures++;
            $display("FAIL midcount_before_reset: p_dat=%h want=02", p_dat);
        end
        sys_bus.sys_addr = AState;
        sys_bus.sys_ren  = 1'b1;
        @(posedge clk);
        #2;
        sys_bus.sys_ren = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({p_dat, n_dat, irq, sys_bus.sys_rdata, sys_bus.sys_ack, sys_bus.sys_err} !== '0) begin
            failures++;
            $display("FAIL midcount_async: p=%h n=%h irq=%b rdata=%h ack=%b err=%b, all must be 0",
                     p_dat, n_dat, irq, sys_bus.sys_rdata, sys_bus.sys_ack, sys_bus.sys_err);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (p_dat !== 8'h00) begin
            failures++;
            $display("FAIL midcount_edge2: p_dat=%h want=00", p_dat);
        end
        @(negedge clk);
        checks++;
        if (p_dat !== 8'h03) begin
            failures++;
            $display("FAIL midcount_edge3: p_dat=%h want=03", p_dat);
        end
        bus_read(AEvent, 32'h0, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL midcount_event: got=%h ack=%b want=%h", got, ack, want);
        end
        bus_read(ADebLen, 32'h0, got, want, ack);
        checks++;
        if (ack !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL midcount_deblen: got=%h ack=%b want=%h", got, ack, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_glitch();
        test_fall_w1c();
        test_set_wins();
        test_bus_decode();
        test_back_to_back();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/red_pitaya_exp_in.md
# red_pitaya_exp_in

Input conditioner for the expansion connector, sitting directly upstream of the housekeeping block's `exp_p_dat_i`/`exp_n_dat_i` inputs. It synchronises the raw P and N pad inputs, debounces each bit with a programmable stability count, and latches rising/falling edge events into sticky status bits with a maskable interrupt. Configuration and status are accessed over the standard system bus.

## Interface
- `DWE`, 8: pins per side (P and N); legal range 1..16.
- `DBW`, 16: debounce counter and threshold width.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `exp_p_pad_i`  in  DWE  raw P-side pad inputs (asynchronous).
- `exp_n_pad_i`  in  DWE  raw N-side pad inputs (asynchronous).
- `exp_p_dat_o`  out  DWE  debounced P-side data, to housekeeping `exp_p_dat_i`.
- `exp_n_dat_o`  out  DWE  debounced N-side data, to housekeeping `exp_n_dat_i`.
- `irq_o`  out  1  level interrupt, registered.
- `sys_addr`  in  32  bus address; bits [19:0] decoded.
- `sys_wdata`  in  32  write data.
- `sys_wen`  in  1  write strobe.
- `sys_ren`  in  1  read strobe.
- `sys_rdata`  out  32  read data, registered.
- `sys_err`  out  1  always 0.
- `sys_ack`  out  1  acknowledge.

Decided: one clock; reset is asynchronous and active-high.

## Operation
- 2·DWE channels. In every register, bits [DWE-1:0] are P pins and bits [16+DWE-1:16] are N pins. All other bits read 0 and ignore writes.
- Per channel:
  - Synchroniser: two flops, `s1` then `s2`.
  - Debounced state `deb` and counter `cnt` [DBW-1:0].
  - When `s2 == deb`: `cnt <= 0`.
  - When `s2 != deb` and `cnt >= DEB_LEN`: `deb <= s2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - A new level must therefore persist DEB_LEN+1 consecutive `s2` samples. A glitch shorter than that resets `cnt` and produces no change.
  - The comparison uses the live DEB_LEN. Lowering DEB_LEN below the current `cnt` makes `deb` update on the next cycle.
- Edge events:
  - A `deb` 0→1 update with the RISE_EN bit set sets the EVENT bit on the same edge as the `deb` update.
  - A `deb` 1→0 update with the FALL_EN bit set does the same.
- `exp_*_dat_o` are `deb` directly.
- `irq_o <= |(EVENT & IRQ_EN)`.
- Register map (addr[19:0]); all writable registers reset to 0:
  - 0x00 DEB_LEN: [DBW-1:0], RW.
  - 0x04 RISE_EN: RW.
  - 0x08 FALL_EN: RW.
  - 0x0C EVENT: sticky. Reads do not clear; a write clears bits where `sys_wdata` = 1 (W1C).
  - 0x10 IRQ_EN: RW.
  - 0x14 STATE: RO, `deb`.
  - 0x18 RAW: RO, `s2`.
  - Any other address: read 0, write ignored, still acknowledged.
- EVENT set and W1C clear of the same bit on the same cycle: set wins, and the bit stays 1.
- Writing RISE_EN/FALL_EN does not affect EVENT bits already latched.

## Timing
- Reset (asynchronous, immediate) clears: `s1`, `s2`, `deb`, `cnt`, all registers, `exp_p_dat_o` = 0, `exp_n_dat_o` = 0, `irq_o` = 0, `sys_rdata` = 0, `sys_ack` = 0, `sys_err` = 0.
- Reset asserted mid-debounce discards the count. After release, DEB_LEN = 0, so a pad held at 1 reaches `deb` = 1 on the 3rd rising edge after release. No EVENT is set, because RISE_EN = 0.
- Pad-to-output latency, with a pad change sampled at edge k:
  - `s1` at k, `s2` at k+1.
  - `deb`/`exp_*_dat_o` and EVENT at k+2+DEB_LEN.
  - `irq_o` at k+3+DEB_LEN.
- Bus:
  - `sys_ack` = 1 exactly one cycle after any cycle with `sys_wen|sys_ren`, and 0 otherwise.
  - `sys_rdata` is valid in that same cycle.
  - A write takes effect on the strobe edge. A read one cycle after a write returns the new value.
- `irq_o` deasserts one cycle after the W1C write edge that clears the last enabled EVENT bit, or after IRQ_EN is cleared.
- No backpressure. Back-to-back strobes each get one ack.

## Test plan
- **Bypass latency:** DEB_LEN = 0, RISE_EN = 0x1, IRQ_EN = 0x1; drive `exp_p_pad_i[0]` 0→1 before edge k. Required: `exp_p_dat_o[0]` = 1 and EVENT = 0x1 at k+2; `irq_o` = 1 at k+3; STATE read = 0x00000001.
- **Glitch rejection:** DEB_LEN = 4; pulse `exp_n_pad_i[2]` high for 4 cycles, then low. Required: `exp_n_dat_o` stays 0, EVENT = 0. Holding it high for 5 cycles gives STATE = 0x00040000 at k+6.
- **Fall event and W1C:** DEB_LEN = 0, FALL_EN = 0x80; fall on P7. Required: EVENT = 0x80. Write EVENT = 0x80: reads 0, and `irq_o` drops one cycle after the write.
- **Set-wins race:** time a W1C write of bit 0 on the exact edge where bit 0's event sets. Required: EVENT[0] = 1 afterward.
- **Async reset mid-count:** DEB_LEN = 100; after 50 stable-high cycles assert `rst_i` between edges. Required: all outputs 0 immediately. Release with the pad held high: `deb` = 1 three edges later, EVENT = 0.
- **Bus decode:** read 0x1C and 0x40. Required: `sys_rdata` = 0, `sys_ack` one cycle after the strobe, `sys_err` = 0. Writing 0xFFFFFFFF to RISE_EN reads back 0x00FF00FF (DWE = 8).
